// File: rtl/tcm_pkg.sv
// Shared types for the data-TCM arbiter: priority state, request bundle and
// read-owner encoding.
package tcm_pkg;

  localparam int TCM_AW = 32;
  localparam int TCM_DW = 32;

  typedef enum logic {
    CPU_PRI = 1'b0,
    EXT_PRI = 1'b1
  } arb_state_t;

  // One port's request fields; the arbiter's AW/DW must equal TCM_AW/TCM_DW.
  typedef struct packed {
    logic                  we;
    logic [TCM_AW-1:0]     addr;
    logic [TCM_DW-1:0]     wdata;
    logic [TCM_DW/8-1:0]   wstrb;
  } tcm_req_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

endpackage

// File: rtl/dtcm_arbiter.sv
// Single-port data-TCM arbiter between the CPU load/store port and an external
// port, with starvation bound, locked external bursts and 1-cycle read return.
module dtcm_arbiter
  import tcm_pkg::*;
#(
  parameter int AW        = TCM_AW,
  parameter int DW        = TCM_DW,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  input  logic [DW/8-1:0] cpu_wstrb,
  output logic            cpu_gnt,
  output logic            cpu_rvalid,
  output logic [DW-1:0]   cpu_rdata,

  input  logic            ext_req,
  input  logic            ext_we,
  input  logic [AW-1:0]   ext_addr,
  input  logic [DW-1:0]   ext_wdata,
  input  logic [DW/8-1:0] ext_wstrb,
  input  logic            ext_lock,
  output logic            ext_gnt,
  output logic            ext_rvalid,
  output logic [DW-1:0]   ext_rdata,

  output logic            dtcm_en,
  output logic [DW/8-1:0] dtcm_we,
  output logic [AW-1:0]   dtcm_addr,
  output logic [DW-1:0]   dtcm_wdata,
  input  logic [DW-1:0]   dtcm_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);
  // The entry beat is granted from CPU_PRI, so EXT_PRI itself carries
  // MAX_BURST-1 beats; burst_cnt holds the EXT_PRI beats already taken.
  localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST >= 2) ? MAX_BURST - 2 : 0);

  arb_state_t    state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic          yield;
  logic          rd_pend;
  logic          rd_owner;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] ext_rdata_q;

  tcm_req_t cpu_r, ext_r, sel;
  logic     ext_win;
  logic     rd_start;

  assign cpu_r = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, wstrb: cpu_wstrb};
  assign ext_r = '{we: ext_we, addr: ext_addr, wdata: ext_wdata, wstrb: ext_wstrb};

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    ext_win = 1'b0;
    if (state == EXT_PRI)
      ext_win = ext_req;
    else
      ext_win = ext_req && (!cpu_req || ((wait_cnt == WAIT_SAT) && !yield));
  end

  assign ext_gnt = reset && ext_win;
  assign cpu_gnt = reset && cpu_req && !ext_win;

  assign sel        = ext_gnt ? ext_r : cpu_r;
  assign dtcm_en    = cpu_gnt | ext_gnt;
  assign dtcm_addr  = sel.addr;
  assign dtcm_wdata = sel.wdata;
  assign dtcm_we    = (dtcm_en && sel.we) ? sel.wstrb : '0;
  assign rd_start   = dtcm_en && !sel.we;

  assign cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
  assign ext_rvalid = rd_pend && (rd_owner == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? dtcm_rdata : cpu_rdata_q;
  assign ext_rdata  = ext_rvalid ? dtcm_rdata : ext_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= CPU_PRI;
      wait_cnt    <= '0;
      burst_cnt   <= '0;
      yield       <= 1'b0;
      rd_pend     <= 1'b0;
      rd_owner    <= OWN_CPU;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      if (!ext_req || ext_gnt)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_SAT)
        wait_cnt <= wait_cnt + 1'b1;

      yield <= 1'b0;
      case (state)
        CPU_PRI: begin
          if (ext_gnt && ext_lock && !yield) begin
            burst_cnt <= '0;
            if (MAX_BURST > 1) state <= EXT_PRI;
            else               yield <= 1'b1;
          end
        end
        EXT_PRI: begin
          if (!(ext_req && ext_lock)) begin
            state     <= CPU_PRI;
            burst_cnt <= '0;
          end else if (burst_cnt == BURST_LAST) begin
            // Burst limit: hand one guaranteed cycle back to the CPU.
            state     <= CPU_PRI;
            burst_cnt <= '0;
            yield     <= 1'b1;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= CPU_PRI;
      endcase

      rd_pend <= rd_start;
      if (rd_start) rd_owner <= ext_gnt ? OWN_EXT : OWN_CPU;
      if (cpu_rvalid) cpu_rdata_q <= dtcm_rdata;
      if (ext_rvalid) ext_rdata_q <= dtcm_rdata;
    end
  end

endmodule
